// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave responder over a byte-addressable memory; independent single-outstanding
// write and read paths, no IDs. Bursts: FIXED/INCR/WRAP with SLVERR on illegal or out-of-range.
module ei_axi4_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 4096
) (
  input  logic                    i_aclk,
  input  logic                    i_aresetn,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready
);

  localparam int unsigned STRB    = DATA_WIDTH / 8;
  localparam int unsigned MEM_AW  = $clog2(MEM_BYTES);
  localparam int unsigned LANE_AW = $clog2(STRB);

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} wstate_e;
  typedef enum logic       {StRIdle, StRData}          rstate_e;

  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0]            size,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] n;
    logic [ADDR_WIDTH-1:0] win;
    n   = ADDR_WIDTH'(1) << size;
    win = n * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    case (burst)
      2'b00:   f_next_addr = addr;
      2'b10:   f_next_addr = (addr & ~(win - ADDR_WIDTH'(1))) +
                             ((addr + n) & (win - ADDR_WIDTH'(1)));
      default: f_next_addr = (addr & ~(n - ADDR_WIDTH'(1))) + n;
    endcase
  endfunction

  function automatic logic f_burst_err(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst);
    f_burst_err = (burst == 2'b11) || (size > 3'(LANE_AW)) ||
                  ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // Upper address bits are never aliased into the array.
  function automatic logic f_oor(input logic [ADDR_WIDTH-1:0] addr);
    f_oor = (addr >= ADDR_WIDTH'(MEM_BYTES));
  endfunction

  logic [7:0] r_mem [MEM_BYTES];

  // ---------------- write path ----------------
  wstate_e               r_wstate;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen;
  logic [7:0]            r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic                  r_wberr;
  logic                  r_werr;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic              w_wfire;
  logic              w_wlast_cnt;
  logic              w_wbeat_err;
  logic              w_wstore;
  logic [MEM_AW-1:0] w_wbase;

  assign w_wfire     = (r_wstate == StWData) && i_wvalid && r_wready;
  assign w_wlast_cnt = (r_wcnt == r_wlen);
  assign w_wbeat_err = r_wberr || f_oor(r_waddr);
  assign w_wstore    = w_wfire && !w_wbeat_err && i_aresetn;
  assign w_wbase     = r_waddr[MEM_AW-1:0] & ~MEM_AW'(STRB - 1);

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_wstate  <= StWIdle;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_wberr   <= 1'b0;
      r_werr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      case (r_wstate)
        StWIdle: begin
          r_awready <= 1'b1;
          if (i_awvalid && r_awready) begin
            r_waddr   <= i_awaddr;
            r_wlen    <= i_awlen;
            r_wsize   <= i_awsize;
            r_wburst  <= i_awburst;
            r_wcnt    <= '0;
            r_wberr   <= f_burst_err(i_awsize, i_awlen, i_awburst);
            r_werr    <= f_burst_err(i_awsize, i_awlen, i_awburst);
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= StWData;
          end
        end
        StWData: begin
          if (w_wfire) begin
            r_waddr <= f_next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
            r_wcnt  <= r_wcnt + 8'd1;
            // Only the beat count ends the burst; a wrong wlast just poisons the response.
            if (w_wlast_cnt) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || w_wbeat_err || !i_wlast) ? 2'b10 : 2'b00;
              r_wstate <= StWResp;
            end else if (w_wbeat_err || i_wlast) begin
              r_werr <= 1'b1;
            end
          end
        end
        StWResp: begin
          if (i_bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_awready <= 1'b1;
            r_wstate  <= StWIdle;
          end
        end
        default: r_wstate <= StWIdle;
      endcase
    end
  end

  always_ff @(posedge i_aclk) begin
    if (w_wstore) begin
      for (int i = 0; i < STRB; i++) begin
        if (i_wstrb[i]) r_mem[w_wbase | MEM_AW'(i)] <= i_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_e               r_rstate;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen;
  logic [7:0]            r_rcnt;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic                  r_rberr;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;

  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_berr;
  logic                  w_rd_err;
  logic [MEM_AW-1:0]     w_rd_base;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Address of the beat to be loaded into the output register on the next edge.
  assign w_rd_addr = (r_rstate == StRIdle) ? i_araddr
                                           : f_next_addr(r_raddr, r_rsize, r_rlen, r_rburst);
  assign w_rd_berr = (r_rstate == StRIdle) ? f_burst_err(i_arsize, i_arlen, i_arburst) : r_rberr;
  assign w_rd_err  = w_rd_berr || f_oor(w_rd_addr);
  assign w_rd_base = w_rd_addr[MEM_AW-1:0] & ~MEM_AW'(STRB - 1);

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < STRB; i++) begin
      w_rd_data[8*i +: 8] = r_mem[w_rd_base | MEM_AW'(i)];
    end
  end

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_rstate  <= StRIdle;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rberr   <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
    end else begin
      case (r_rstate)
        StRIdle: begin
          r_arready <= 1'b1;
          if (i_arvalid && r_arready) begin
            r_raddr   <= i_araddr;
            r_rlen    <= i_arlen;
            r_rsize   <= i_arsize;
            r_rburst  <= i_arburst;
            r_rberr   <= w_rd_berr;
            r_rcnt    <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_err ? '0 : w_rd_data;
            r_rresp   <= w_rd_err ? 2'b10 : 2'b00;
            r_rlast   <= (i_arlen == 8'd0);
            r_rstate  <= StRData;
          end
        end
        StRData: begin
          if (i_rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_rdata   <= '0;
              r_rresp   <= 2'b00;
              r_arready <= 1'b1;
              r_rstate  <= StRIdle;
            end else begin
              r_raddr <= w_rd_addr;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rdata <= w_rd_err ? '0 : w_rd_data;
              r_rresp <= w_rd_err ? 2'b10 : 2'b00;
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= StRIdle;
      endcase
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_rlast   = r_rlast;

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed bench for ei_axi4_slave_mem: byte-array model plus expected-beat queues,
// checked every cycle by one compare process, with literal pins on key results.
module tb_ei_axi4_slave_mem;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, arvalid, wvalid, wlast, bready, rready;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  ei_axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(4096)) dut (
    .i_aclk(clk), .i_aresetn(aresetn),
    .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_arvalid(arvalid), .o_arready(arready),
    .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        lst;
  } rbeat_t;

  rbeat_t      q_r[$];
  logic [1:0]  q_b[$];
  logic [7:0]  mm [4096];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rx [16];
  logic [1:0]  rxr [16];
  logic [1:0]  b_got;
  int          n_total = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bad_burst(input logic [2:0] sz, input logic [7:0] len,
                                   input logic [1:0] br);
    return (br == 2'b11) || ((1 << sz) > 4) ||
           ((br == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // k-th beat address computed directly from the burst start, not by stepping.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] sz,
                                            input logic [7:0] len, input logic [1:0] br,
                                            input int k);
    longint n, win, s, base;
    n   = longint'(1) << sz;
    win = n * (longint'(len) + 1);
    s   = longint'(start);
    if (br == 2'b00) return start;
    if (br == 2'b01) return (k == 0) ? start : 32'((s / n) * n + k * n);
    base = (s / win) * win;
    return 32'(base + ((s - base) + k * n) % win);
  endfunction

  // One compare process: every valid cycle is checked against the queue head.
  always @(negedge clk) begin
    if (aresetn) begin
      if (rvalid) begin
        if (q_r.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
        else begin
          chk("r_data", rdata, q_r[0].data);
          chk("r_resp", 32'(rresp), 32'(q_r[0].resp));
          chk("r_last", 32'(rlast), 32'(q_r[0].lst));
          if (rready) void'(q_r.pop_front());
        end
      end
      if (bvalid) begin
        if (q_b.size() == 0) chk("b_unexpected", 32'(bvalid), 32'd0);
        else begin
          chk("b_resp", 32'(bresp), 32'(q_b[0]));
          if (bready) void'(q_b.pop_front());
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] br, input int bstall, input bit bad_last);
    bit berr, err;
    logic [31:0] ba;
    int g;
    berr = bad_burst(sz, len, br);
    err  = berr;
    for (int k = 0; k <= int'(len); k++) begin
      ba = beat_addr(a, sz, len, br, k);
      if (ba >= 32'd4096) err = 1'b1;
      else if (!berr)
        for (int i = 0; i < 4; i++) if (ws[k][i]) mm[{ba[11:2], 2'b00} + i] = wd[k][8*i +: 8];
    end
    if (bad_last && len > 0) err = 1'b1;
    q_b.push_back(err ? 2'b10 : 2'b00);
    b_got  = 2'b11;
    bready = (bstall == 0);
    @(posedge clk); #1;
    awaddr = a; awlen = len; awsize = sz; awburst = br; awvalid = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!awready && g < 50);
    if (!awready) chk("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k];
      wlast  = (k == int'(len)) || (bad_last && k == 0);
      g = 0;
      do begin @(negedge clk); g++; end while (!wready && g < 50);
      if (!wready) chk("w_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    chk("b_latency", 32'(bvalid), 32'd1);
    for (int c = 0; c < bstall; c++) begin
      @(posedge clk); @(negedge clk);
      chk("b_hold", 32'(bvalid), 32'd1);
    end
    if (bstall > 0) begin @(posedge clk); #1; bready = 1'b1; end
    g = 0;
    while (!(bvalid && bready) && g < 50) begin @(negedge clk); g++; end
    if (bvalid && bready) b_got = bresp;
    else chk("b_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] br, input int stall);
    bit berr, e, stalled;
    logic [31:0] ba;
    rbeat_t bt;
    int b, g, cnt;
    berr = bad_burst(sz, len, br);
    for (int k = 0; k <= int'(len); k++) begin
      ba = beat_addr(a, sz, len, br, k);
      e  = berr || (ba >= 32'd4096);
      b  = int'({ba[11:2], 2'b00});
      bt.data = e ? 32'd0 : {mm[b+3], mm[b+2], mm[b+1], mm[b]};
      bt.resp = e ? 2'b10 : 2'b00;
      bt.lst  = (k == int'(len));
      q_r.push_back(bt);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    araddr = a; arlen = len; arsize = sz; arburst = br; arvalid = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!arready && g < 50);
    if (!arready) chk("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    cnt = 0; g = 0; stalled = 1'b0;
    while (cnt <= int'(len) && g < 200) begin
      @(negedge clk);
      if (g == 0) chk("r_latency", 32'(rvalid), 32'd1);
      g++;
      if (rvalid && rready) begin rx[cnt] = rdata; rxr[cnt] = rresp; cnt++; end
      @(posedge clk); #1;
      if (stall > 0 && cnt == 2 && !stalled) begin
        stalled = 1'b1;
        rready  = 1'b0;
        for (int c = 0; c < stall; c++) begin
          @(negedge clk);
          chk("r_hold", 32'(rvalid), 32'd1);
          @(posedge clk); #1;
        end
        rready = 1'b1;
      end
    end
    if (cnt <= int'(len)) chk("r_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("ar_ready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    awaddr = '0; araddr = '0; awlen = '0; arlen = '0; awsize = 3'd2; arsize = 3'd2;
    awburst = 2'b01; arburst = 2'b01; wdata = '0; wstrb = 4'hF; bready = 1'b1; rready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    chk("rst_rlast",   32'(rlast),   32'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    chk("rel_awready_still0", 32'(awready), 32'd0);
    @(negedge clk);
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_arready", 32'(arready), 32'd1);
    chk("rel_wready",  32'(wready),  32'd0);

    // INCR write/read
    for (int k = 0; k < 4; k++) begin wd[k] = 32'hA0 + k; ws[k] = 4'hF; end
    do_write(32'h10, 8'd3, 3'd2, 2'b01, 0, 1'b0);
    chk("incr_bresp", 32'(b_got), 32'd0);
    do_read(32'h10, 8'd3, 3'd2, 2'b01, 0);
    chk("incr_rx0", rx[0], 32'hA0);
    chk("incr_rx3", rx[3], 32'hA3);

    // WRAP write/read
    for (int k = 0; k < 4; k++) begin wd[k] = k + 1; ws[k] = 4'hF; end
    do_write(32'h38, 8'd3, 3'd2, 2'b10, 0, 1'b0);
    chk("wrap_bresp", 32'(b_got), 32'd0);
    do_read(32'h38, 8'd3, 3'd2, 2'b10, 0);
    chk("wrap_rx2", rx[2], 32'd3);
    do_read(32'h30, 8'd3, 3'd2, 2'b01, 0);
    chk("wrap_b30", rx[0], 32'd3);
    chk("wrap_b34", rx[1], 32'd4);
    chk("wrap_b38", rx[2], 32'd1);
    chk("wrap_b3c", rx[3], 32'd2);

    // Byte strobes
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(32'h0, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    do_write(32'h0, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    do_read(32'h0, 8'd0, 3'd2, 2'b01, 0);
    chk("strb_rx", rx[0], 32'hFF22_FF44);

    // FIXED: both beats land on the same word
    wd[0] = 32'h55; wd[1] = 32'h66; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h80, 8'd1, 3'd2, 2'b00, 0, 1'b0);
    do_read(32'h80, 8'd0, 3'd2, 2'b01, 0);
    chk("fixed_rx", rx[0], 32'h66);

    // Error bursts: memory untouched, SLVERR
    for (int k = 0; k < 4; k++) begin wd[k] = 32'hDEAD_BEEF; ws[k] = 4'hF; end
    do_write(32'h10, 8'd3, 3'd2, 2'b11, 0, 1'b0);
    chk("err_burst11_bresp", 32'(b_got), 32'd2);
    do_write(32'h10, 8'd2, 3'd2, 2'b10, 0, 1'b0);
    chk("err_wraplen2_bresp", 32'(b_got), 32'd2);
    do_write(32'h1000, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    chk("err_oor_bresp", 32'(b_got), 32'd2);
    do_read(32'h10, 8'd3, 3'd2, 2'b01, 0);
    chk("err_unchanged0", rx[0], 32'hA0);
    chk("err_unchanged3", rx[3], 32'hA3);
    do_read(32'h10, 8'd3, 3'd2, 2'b11, 0);
    chk("err_r11_data", rx[1], 32'd0);
    chk("err_r11_resp", 32'(rxr[3]), 32'd2);
    do_read(32'h10, 8'd2, 3'd2, 2'b10, 0);
    chk("err_rwrap_resp", 32'(rxr[2]), 32'd2);
    do_read(32'h1000, 8'd0, 3'd2, 2'b01, 0);
    chk("err_roor_data", rx[0], 32'd0);
    chk("err_roor_resp", 32'(rxr[0]), 32'd2);

    // Back-pressure
    do_read(32'h10, 8'd3, 3'd2, 2'b01, 5);
    chk("rstall_rx2", rx[2], 32'hA2);
    wd[0] = 32'h5A5A_0000; wd[1] = 32'h5A5A_0001; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h20, 8'd1, 3'd2, 2'b01, 3, 1'b0);
    chk("bstall_bresp", 32'(b_got), 32'd0);
    do_read(32'h20, 8'd1, 3'd2, 2'b01, 0);
    chk("bstall_rx1", rx[1], 32'h5A5A_0001);

    // Early wlast
    wd[0] = 32'h1; wd[1] = 32'h2;
    do_write(32'h40, 8'd1, 3'd2, 2'b01, 0, 1'b1);
    chk("badlast_bresp", 32'(b_got), 32'd2);

    // Reset during beat 2 of a write burst
    @(posedge clk); #1;
    awaddr = 32'h100; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    chk("mid_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wvalid = 1'b1; wdata = 32'hC0 + k; wstrb = 4'hF; wlast = 1'b0;
      @(negedge clk);
      chk("mid_wready", 32'(wready), 32'd1);
      for (int i = 0; i < 4; i++) mm[32'h100 + 4 * k + i] = wdata[8*i +: 8];
      @(posedge clk); #1;
    end
    wdata = 32'hC2; aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1; wvalid = 1'b0;
    q_b.delete();
    @(negedge clk);
    chk("mid_rst_awready", 32'(awready), 32'd0);
    chk("mid_rst_wready",  32'(wready),  32'd0);
    chk("mid_rst_bvalid",  32'(bvalid),  32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd0);
    chk("mid_rst_rvalid",  32'(rvalid),  32'd0);
    wd[0] = 32'hE0; wd[1] = 32'hE1; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h200, 8'd1, 3'd2, 2'b01, 0, 1'b0);
    chk("post_rst_bresp", 32'(b_got), 32'd0);
    do_read(32'h200, 8'd1, 3'd2, 2'b01, 0);
    chk("post_rst_rx1", rx[1], 32'hE1);
    do_read(32'h100, 8'd1, 3'd2, 2'b01, 0);
    chk("pre_rst_beat0", rx[0], 32'hC0);
    chk("pre_rst_beat1", rx[1], 32'hC1);
    do_read(32'h10, 8'd3, 3'd2, 2'b01, 0);
    chk("kept_rx0", rx[0], 32'hA0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("q_r_drained", 32'(q_r.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
